// File: rtl/seg_pkg.sv
// ============================================================================
// Module  : seg_pkg
// Purpose : Shared constants, hex segment table and scan-state type for the
//           8-digit multiplexed 7-segment driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

   localparam int NUM_DIGITS = 8;

   // Lit-segment patterns {g,f,e,d,c,b,a}, indexed by nibble value (entry 0 is rightmost).
   localparam logic [15:0][6:0] SEG_HEX_LUT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } seg_state_t;

endpackage : seg_pkg

`default_nettype wire

// File: rtl/seg_hex_decode.sv
// ============================================================================
// Module  : seg_hex_decode
// Purpose : Combinational nibble + decimal point to active-low segment pattern.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] i_nib,
   input  logic       i_dp,
   output logic [7:0] o_seg
);

   assign o_seg = ~{i_dp, SEG_HEX_LUT[i_nib]};

endmodule : seg_hex_decode

`default_nettype wire

// File: rtl/seg7_scan_drv.sv
// ============================================================================
// Module  : seg7_scan_drv
// Purpose : Round-robin 8-digit 7-segment scanner with per-slot dead-time and
//           frame-boundary data commit. SEG_LZ_BLANK_EN enables leading-zero
//           suppression.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_drv
   import seg_pkg::*;
#(
   parameter int SCAN_DIV  = 100_000,
   parameter int BLANK_CYC = 16
) (
   input  logic        sys_clk_i,
   input  logic        ext_rst_n,
   input  logic        wr_en_i,
   input  logic [31:0] wr_data_i,
   input  logic [7:0]  dp_i,
   input  logic [7:0]  digit_en_i,
   output logic        upd_pend_o,
   output logic        frame_o,
   output logic [7:0]  seg_an_o,
   output logic [7:0]  seg_out_o
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   seg_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic             r_frame;
   logic [7:0]       r_an;
   logic [7:0]       r_seg;

   logic [31:0]      r_pend_data;
   logic [7:0]       r_pend_dp;
   logic [7:0]       r_pend_en;
   logic             r_pend;
   logic [31:0]      r_disp_data;
   logic [7:0]       r_disp_dp;
   logic [7:0]       r_disp_en;

   logic             w_cnt_wrap;
   logic             w_blank_end;
   logic             w_frame_wrap;
   logic [3:0]       w_nib;
   logic [7:0]       w_seg_show;
   logic [7:0]       w_an_show;
   logic [7:0]       w_en_eff;

   assign w_cnt_wrap   = (r_cnt == CNT_W'(SCAN_DIV - 1));
   assign w_blank_end  = (r_cnt == CNT_W'(BLANK_CYC - 1));
   assign w_frame_wrap = w_cnt_wrap && (r_idx == 3'd7);
   assign w_nib        = r_disp_data[{r_idx, 2'b00} +: 4];

   seg_hex_decode u_dec (
      .i_nib (w_nib),
      .i_dp  (r_disp_dp[r_idx]),
      .o_seg (w_seg_show)
   );

`ifdef SEG_LZ_BLANK_EN
   logic [7:0] w_lz_keep;

   // Scanning from the top digit down, a digit is kept once any non-zero nibble
   // at or above it has been seen; digit 0 and digits with a lit dp always stay.
   always_comb begin
      logic v_seen;
      v_seen    = 1'b0;
      w_lz_keep = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         v_seen       = v_seen | (r_disp_data[k*4 +: 4] != 4'h0) | (k == 0);
         w_lz_keep[k] = v_seen | r_disp_dp[k];
      end
   end

   assign w_en_eff = r_disp_en & w_lz_keep;
`else
   assign w_en_eff = r_disp_en;
`endif

   always_comb begin
      w_an_show        = AN_OFF;
      w_an_show[r_idx] = ~w_en_eff[r_idx];
   end

   always_ff @(posedge sys_clk_i or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         r_state <= ST_BLANK;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_frame <= 1'b0;
         r_an    <= AN_OFF;
         r_seg   <= SEG_OFF;
      end else begin
         r_frame <= w_frame_wrap;
         if (w_cnt_wrap) begin
            r_cnt   <= '0;
            r_idx   <= r_idx + 3'd1;
            r_state <= ST_BLANK;
            r_an    <= AN_OFF;
            r_seg   <= SEG_OFF;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            case (r_state)
               ST_BLANK: begin
                  if (w_blank_end) begin
                     r_state <= ST_SHOW;
                     r_an    <= w_an_show;
                     r_seg   <= w_seg_show;
                  end
               end
               ST_SHOW: begin
                  r_an  <= w_an_show;
                  r_seg <= w_seg_show;
               end
               default: begin
                  r_state <= ST_BLANK;
                  r_an    <= AN_OFF;
                  r_seg   <= SEG_OFF;
               end
            endcase
         end
      end
   end

   // A write coinciding with the commit lands in pending after the old pending
   // word has moved to the display, so upd_pend_o stays high.
   always_ff @(posedge sys_clk_i or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         r_pend_data <= '0;
         r_pend_dp   <= '0;
         r_pend_en   <= 8'hFF;
         r_pend      <= 1'b0;
         r_disp_data <= '0;
         r_disp_dp   <= '0;
         r_disp_en   <= 8'hFF;
      end else begin
         if (w_frame_wrap && r_pend) begin
            r_disp_data <= r_pend_data;
            r_disp_dp   <= r_pend_dp;
            r_disp_en   <= r_pend_en;
         end
         if (wr_en_i) begin
            r_pend_data <= wr_data_i;
            r_pend_dp   <= dp_i;
            r_pend_en   <= digit_en_i;
            r_pend      <= 1'b1;
         end else if (w_frame_wrap) begin
            r_pend <= 1'b0;
         end
      end
   end

   assign upd_pend_o = r_pend;
   assign frame_o    = r_frame;
   assign seg_an_o   = r_an;
   assign seg_out_o  = r_seg;

endmodule : seg7_scan_drv

`default_nettype wire

// File: tb/tb_seg7_scan_drv.sv
// ============================================================================
// Module  : tb_seg7_scan_drv
// Purpose : Randomised self-checking bench for seg7_scan_drv against a
//           cycle-count based reference model (SCAN_DIV=8, BLANK_CYC=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_drv;

   localparam int SD = 8;
   localparam int BC = 2;
   localparam int FRAME = SD * 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [7:0]  dp;
   logic [7:0]  den;
   logic        upd_pend;
   logic        frame;
   logic [7:0]  seg_an;
   logic [7:0]  seg_out;

   seg7_scan_drv #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .sys_clk_i  (clk),
      .ext_rst_n  (rst_n),
      .wr_en_i    (wr_en),
      .wr_data_i  (wr_data),
      .dp_i       (dp),
      .digit_en_i (den),
      .upd_pend_o (upd_pend),
      .frame_o    (frame),
      .seg_an_o   (seg_an),
      .seg_out_o  (seg_out)
   );

   always #5 clk = ~clk;

   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int          n_cmp = 0;
   int          n_err = 0;

   // Reference model: elapsed clock edges since reset release plus the two data words.
   int          m_k;
   logic [31:0] m_disp, m_pdata;
   logic [7:0]  m_dp, m_en, m_pdp, m_pen;
   logic        m_pend;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @k=%0d: got %h expected %h", tag, m_k, got, exp);
      end
   endtask

   task automatic model_reset();
      m_k = 0; m_disp = '0; m_dp = '0; m_en = 8'hFF;
      m_pdata = '0; m_pdp = '0; m_pen = 8'hFF; m_pend = 1'b0;
   endtask

   function automatic bit lz_dark(input int d);
`ifdef SEG_LZ_BLANK_EN
      int top = 0;
      for (int i = 0; i < 8; i++)
         if (((m_disp >> (4 * i)) & 32'hF) != 0) top = i;
      return (d > top) && !m_dp[d];
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_all();
      int          slot, ph;
      logic [3:0]  nib;
      logic [7:0]  e_an, e_seg;
      slot = (m_k / SD) % 8;
      ph   = m_k % SD;
      e_an = 8'hFF;
      e_seg = 8'hFF;
      if (ph >= BC) begin
         nib   = 4'((m_disp >> (4 * slot)) & 32'hF);
         e_seg = ~{m_dp[slot], hex_tab[nib]};
         if (m_en[slot] && !lz_dark(slot)) e_an = ~(8'h01 << slot);
      end
      chk_val("anode", {24'h0, seg_an}, {24'h0, e_an});
      chk_val("segs", {24'h0, seg_out}, {24'h0, e_seg});
      chk_val("pend", {31'h0, upd_pend}, {31'h0, m_pend});
      chk_val("frame", {31'h0, frame}, {31'h0, (m_k > 0) && (m_k % FRAME == 0)});
   endtask

   // One clock: model advances on the edge using the driven inputs; outputs checked on negedge.
   task automatic tick();
      @(posedge clk);
      m_k++;
      if ((m_k % FRAME == 0) && m_pend) begin
         m_disp = m_pdata; m_dp = m_pdp; m_en = m_pen; m_pend = 1'b0;
      end
      if (wr_en) begin
         m_pdata = wr_data; m_pdp = dp; m_pen = den; m_pend = 1'b1;
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
      wr_en = 1'b1; wr_data = d; dp = p; den = e;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic align_to(input int ph_mod, input int want);
      while ((m_k % ph_mod) != want) tick();
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; dp = '0; den = 8'hFF;
      model_reset();
      repeat (3) @(negedge clk);
      chk_val("rst_an", {24'h0, seg_an}, 32'hFF);
      chk_val("rst_seg", {24'h0, seg_out}, 32'hFF);
      rst_n = 1'b1;
      check_all();

      run(10);
      chk_val("first_zero", {24'h0, seg_out}, 32'hC0);

      wr(32'h1234_ABCD, 8'h00, 8'hFF);
      run(2 * FRAME);

      wr(32'h1111_1111, 8'h00, 8'hFF);
      run(5);
      wr(32'h2222_2222, 8'h00, 8'hFF);
      run(FRAME + 10);

      wr(32'h4444_4444, 8'h00, 8'hFF);
      align_to(FRAME, FRAME - 1);
      wr(32'h5555_5555, 8'h00, 8'hFF);
      chk_val("wr_on_commit_pend", {31'h0, upd_pend}, 32'h1);
      run(2 * FRAME);

      wr(32'h8765_4321, 8'h01, 8'h0F);
      run(2 * FRAME);

      wr(32'h0000_00A5, 8'h00, 8'hFF);
      run(2 * FRAME);
      wr(32'h0000_0000, 8'h00, 8'hFF);
      run(2 * FRAME);

      for (int i = 0; i < 1500; i++) begin
         wr_en   = ($urandom_range(0, 15) == 0);
         wr_data = $urandom >> $urandom_range(0, 31);
         dp      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         den     = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
         tick();
      end
      wr_en = 1'b0;

      // Asynchronous reset in the middle of a SHOW slot with a write still pending.
      wr(32'h9999_9999, 8'hFF, 8'hFF);
      align_to(SD, 4);
      #1 rst_n = 1'b0;
      #1;
      chk_val("async_an", {24'h0, seg_an}, 32'hFF);
      chk_val("async_seg", {24'h0, seg_out}, 32'hFF);
      chk_val("async_pend", {31'h0, upd_pend}, 32'h0);
      chk_val("async_frame", {31'h0, frame}, 32'h0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_all();
      run(FRAME + 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_seg7_scan_drv

`default_nettype wire
